// File: rtl/fp_cmp_pipe.sv
// fp_cmp_pipe: two-stage IEEE-754 comparator and MIN/MAX unit.
// Field widths are set by EXP_W and MAN_W. The operand width is 1+EXP_W+MAN_W.
// Stage 1 classifies both operands and compares their magnitudes.
// Stage 2 resolves the signs and registers all outputs.
// A valid/ready handshake runs on both ends, and backpressure ripples
// combinationally back to in_ready.
// Optional: define FP_CMP_INVALID_STICKY_EN to add the invalid_sticky flag
// and its clr_sticky input.
module fp_cmp_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   gr,
  output logic                   lr,
  output logic                   eq,
  output logic                   unord,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   snan
`ifdef FP_CMP_INVALID_STICKY_EN
  ,
  input  logic                   clr_sticky,
  output logic                   invalid_sticky
`endif
);

  localparam int W = 1 + EXP_W + MAN_W;
  // Canonical quiet NaN: sign 0, exponent all ones, only the quiet bit set.
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic f_is_nan(input logic [W-1:0] x);
    return (&x[W-2:MAN_W]) && (|x[MAN_W-1:0]);
  endfunction

  function automatic logic f_is_zero(input logic [W-1:0] x);
    return ~|x[W-2:0];
  endfunction

  // A signalling NaN has its quiet bit (the mantissa MSB) clear.
  function automatic logic f_is_snan(input logic [W-1:0] x);
    return f_is_nan(x) && !x[MAN_W-1];
  endfunction

  logic           vld_p1, vld_p2;
  logic           adv_p1, adv_p2;
  logic [W-1:0]   a_p1, b_p1;
  logic [1:0]     op_p1;
  logic           a_nan_p1, b_nan_p1, a_zero_p1, b_zero_p1, snan_p1;
  logic           mag_gt_p1, mag_eq_p1;
  logic           gr_p2, lr_p2, eq_p2, unord_p2, snan_p2;
  logic [W-1:0]   res_p2;
  logic           gr_n, lr_n, eq_n, unord_n;
  logic [W-1:0]   res_n;
  logic           sa_p1, sb_p1, is_max_p1;

  // ---- stage 0: handshake. A stage advances when it is empty or its successor advances.
  assign adv_p2   = ~vld_p2 | out_ready;
  assign adv_p1   = ~vld_p1 | adv_p2;
  assign in_ready = adv_p1;

  // Stage 1 valid bit: filled on an accepted input, emptied when it moves on without a refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (adv_p1) begin
      vld_p1 <= in_valid;
    end
  end

  // ---- stage 1: capture operands, classify them, and compare magnitudes without the sign bit.
  always_ff @(posedge clk) begin
    if (in_valid && adv_p1) begin
      a_p1      <= A;
      b_p1      <= B;
      op_p1     <= op;
      a_nan_p1  <= f_is_nan(A);
      b_nan_p1  <= f_is_nan(B);
      a_zero_p1 <= f_is_zero(A);
      b_zero_p1 <= f_is_zero(B);
      snan_p1   <= f_is_snan(A) | f_is_snan(B);
      mag_gt_p1 <= A[W-2:0] > B[W-2:0];
      mag_eq_p1 <= A[W-2:0] == B[W-2:0];
    end
  end

  assign sa_p1     = a_p1[W-1];
  assign sb_p1     = b_p1[W-1];
  assign is_max_p1 = op_p1[1];

  // Sign resolution and MIN/MAX selection for the operation sitting in stage 1.
  always_comb begin
    gr_n    = 1'b0;
    lr_n    = 1'b0;
    eq_n    = 1'b0;
    unord_n = 1'b0;
    res_n   = a_p1;
    if (a_nan_p1 || b_nan_p1) begin
      unord_n = 1'b1;
    end else if (a_zero_p1 && b_zero_p1) begin
      eq_n = 1'b1;
    end else if (sa_p1 != sb_p1) begin
      gr_n = ~sa_p1;
      lr_n = sa_p1;
    end else if (!sa_p1) begin
      gr_n = mag_gt_p1;
      eq_n = mag_eq_p1;
      lr_n = ~mag_gt_p1 & ~mag_eq_p1;
    end else begin
      gr_n = ~mag_gt_p1 & ~mag_eq_p1;
      eq_n = mag_eq_p1;
      lr_n = mag_gt_p1;
    end
    case (op_p1)
      2'b01, 2'b10: begin
        if (a_nan_p1 && b_nan_p1)       res_n = QNAN;
        else if (a_nan_p1)              res_n = b_p1;
        else if (b_nan_p1)              res_n = a_p1;
        // Zeros compare equal, but MIN prefers -0 and MAX prefers +0.
        else if (a_zero_p1 && b_zero_p1) res_n = (sa_p1 ^ is_max_p1) ? a_p1 : b_p1;
        else if (is_max_p1)             res_n = lr_n ? b_p1 : a_p1;
        else                            res_n = gr_n ? b_p1 : a_p1;
      end
      default: res_n = a_p1;
    endcase
  end

  // ---- stage 2: registered outputs. They load only on advance, so they hold during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      gr_p2    <= 1'b0;
      lr_p2    <= 1'b0;
      eq_p2    <= 1'b0;
      unord_p2 <= 1'b0;
      snan_p2  <= 1'b0;
      res_p2   <= '0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        gr_p2    <= gr_n;
        lr_p2    <= lr_n;
        eq_p2    <= eq_n;
        unord_p2 <= unord_n;
        snan_p2  <= snan_p1;
        res_p2   <= res_n;
      end
    end
  end

  assign out_valid = vld_p2;
  assign gr        = gr_p2;
  assign lr        = lr_p2;
  assign eq        = eq_p2;
  assign unord     = unord_p2;
  assign snan      = snan_p2;
  assign result    = res_p2;

`ifdef FP_CMP_INVALID_STICKY_EN
  logic cmp_p2;
  logic sticky;

  // CMP mode (including the reserved encoding) travels with the result to qualify the sticky flag.
  always_ff @(posedge clk) begin
    if (adv_p2 && vld_p1) begin
      cmp_p2 <= ~^op_p1;
    end
  end

  // Invalid sticky: set on a consumed invalid result; when set and clear coincide, set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= 1'b0;
    end else if (vld_p2 && out_ready && (snan_p2 || (unord_p2 && cmp_p2))) begin
      sticky <= 1'b1;
    end else if (clr_sticky) begin
      sticky <= 1'b0;
    end
  end

  assign invalid_sticky = sticky;
`endif

endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Directed bench for fp_cmp_pipe.
// It covers single-precision compare and MIN/MAX vectors, a stalled stream,
// an asynchronous reset while the pipe is full, and a half-precision instance.
module tb_fp_cmp_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  op;
  logic [31:0] a, b, result;
  logic        gr, lr, eq, unord, snan;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [1:0]  h_op;
  logic [15:0] h_a, h_b, h_result;
  logic        h_gr, h_lr, h_eq, h_unord, h_snan;

`ifdef FP_CMP_INVALID_STICKY_EN
  logic clr_sticky, invalid_sticky, h_clr_sticky, h_invalid_sticky;
`endif

  int checks = 0;
  int errors = 0;

  fp_cmp_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready), .gr(gr), .lr(lr),
    .eq(eq), .unord(unord), .result(result), .snan(snan)
`ifdef FP_CMP_INVALID_STICKY_EN
    , .clr_sticky(clr_sticky), .invalid_sticky(invalid_sticky)
`endif
  );

  fp_cmp_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready), .op(h_op),
    .A(h_a), .B(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready), .gr(h_gr),
    .lr(h_lr), .eq(h_eq), .unord(h_unord), .result(h_result), .snan(h_snan)
`ifdef FP_CMP_INVALID_STICKY_EN
    , .clr_sticky(h_clr_sticky), .invalid_sticky(h_invalid_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation into an empty pipe, confirm the 2-cycle latency, then check the outputs.
  task automatic run_op(input string name, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [1:0] iop, input logic [3:0] ef,
                        input logic [31:0] er, input logic es);
    @(negedge clk);
    in_valid = 1'b1; a = ia; b = ib; op = iop; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, ".latency1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({name, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({name, ".flags"}, 32'({gr, lr, eq, unord}), 32'(ef));
    chk({name, ".result"}, result, er);
    chk({name, ".snan"}, 32'(snan), 32'(es));
  endtask

  localparam logic [1:0] CMP = 2'b00, MIN = 2'b01, MAX = 2'b10, RSV = 2'b11;
  // Flag nibble order is {gr, lr, eq, unord}.
  localparam logic [3:0] F_GT = 4'b1000, F_LT = 4'b0100, F_EQ = 4'b0010, F_UN = 4'b0001;

  initial begin
    int sent;
    int rcv;
    int done_cyc;
    logic [3:0] sf;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = CMP; a = '0; b = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_op = CMP; h_a = '0; h_b = '0;
`ifdef FP_CMP_INVALID_STICKY_EN
    clr_sticky = 1'b0; h_clr_sticky = 1'b0;
`endif
    #12;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.flags", 32'({gr, lr, eq, unord, snan}), 32'd0);
    chk("reset.result", result, 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("one_lt_two", 32'h3F800000, 32'h40000000, CMP, F_LT, 32'h3F800000, 1'b0);
    run_op("negz_cmp",   32'h80000000, 32'h00000000, CMP, F_EQ, 32'h80000000, 1'b0);
    run_op("negz_min",   32'h80000000, 32'h00000000, MIN, F_EQ, 32'h80000000, 1'b0);
    run_op("negz_max",   32'h80000000, 32'h00000000, MAX, F_EQ, 32'h00000000, 1'b0);
    run_op("posz_min",   32'h00000000, 32'h80000000, MIN, F_EQ, 32'h80000000, 1'b0);
    run_op("posz_max",   32'h00000000, 32'h80000000, MAX, F_EQ, 32'h00000000, 1'b0);
    run_op("neg3_neg1",  32'hC0400000, 32'hBF800000, MAX, F_LT, 32'hBF800000, 1'b0);
    run_op("neg3_min",   32'hC0400000, 32'hBF800000, MIN, F_LT, 32'hC0400000, 1'b0);
    run_op("pos_neg",    32'h3F800000, 32'hC0000000, CMP, F_GT, 32'h3F800000, 1'b0);
    run_op("qnan_min",   32'h7FC00000, 32'h3F800000, MIN, F_UN, 32'h3F800000, 1'b0);
`ifdef FP_CMP_INVALID_STICKY_EN
    @(negedge clk);
    chk("sticky.min_unord", 32'(invalid_sticky), 32'd0);
`endif
    run_op("snan_both",  32'h7F800001, 32'h7F800001, MAX, F_UN, 32'h7FC00000, 1'b1);
`ifdef FP_CMP_INVALID_STICKY_EN
    @(negedge clk);
    chk("sticky.set", 32'(invalid_sticky), 32'd1);
    @(negedge clk);
    chk("sticky.hold", 32'(invalid_sticky), 32'd1);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk("sticky.clear", 32'(invalid_sticky), 32'd0);
`endif
    run_op("snan_one",   32'h7F800001, 32'h3F800000, MAX, F_UN, 32'h3F800000, 1'b1);
    run_op("b_nan_min",  32'h3F800000, 32'hFFC00000, MIN, F_UN, 32'h3F800000, 1'b0);
    run_op("inf_gt_max", 32'h7F800000, 32'h7F7FFFFF, CMP, F_GT, 32'h7F800000, 1'b0);
    run_op("ninf_eq",    32'hFF800000, 32'hFF800000, CMP, F_EQ, 32'hFF800000, 1'b0);
    run_op("subn_max",   32'h00000001, 32'h00000000, MAX, F_GT, 32'h00000001, 1'b0);
    run_op("reserved",   32'h3F800000, 32'h40000000, RSV, F_LT, 32'h3F800000, 1'b0);

    // Stream of 8 operations; the consumer stalls in cycles 3-5.
    // A = 0x40000000+i and B = 0x40000004, so items 0-3 give lt, item 4 gives eq, items 5-7 give gt.
    sent = 0; rcv = 0; done_cyc = -1;
    for (int c = 0; c < 40 && rcv < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 8);
      a = 32'h40000000 + 32'(sent); b = 32'h40000004; op = CMP;
      #1;
      chk($sformatf("stream.in_ready.c%0d", c), 32'(in_ready),
          32'(!((sent - rcv) == 2 && !out_ready)));
      if (out_valid) begin
        sf = (rcv < 4) ? F_LT : ((rcv == 4) ? F_EQ : F_GT);
        chk($sformatf("stream.result.c%0d", c), result, 32'h40000000 + 32'(rcv));
        chk($sformatf("stream.flags.c%0d", c), 32'({gr, lr, eq, unord}), 32'(sf));
        if (out_ready) begin
          rcv++;
          if (rcv == 8) done_cyc = c;
        end
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    chk("stream.count", 32'(rcv), 32'd8);
    chk("stream.done_cycle", 32'(done_cyc), 32'd12);

    // Fill both stages with the consumer stalled, then reset asynchronously.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 32'h3F800000; b = 32'h40000000; op = CMP;
    @(negedge clk);
    a = 32'h40000000; b = 32'h3F800000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("full.out_valid", 32'(out_valid), 32'd1);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.flags", 32'({gr, lr, eq, unord, snan}), 32'd0);
    chk("arst.result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("arst.in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("arst.no_stale%0d", k), 32'(out_valid), 32'd0);
    end

    // Half precision: +1.0 compared with -1.0.
    @(negedge clk);
    h_in_valid = 1'b1; h_a = 16'h3C00; h_b = 16'hBC00; h_op = CMP; h_out_ready = 1'b1;
    @(negedge clk);
    h_in_valid = 1'b0;
    @(negedge clk);
    chk("half.out_valid", 32'(h_out_valid), 32'd1);
    chk("half.flags", 32'({h_gr, h_lr, h_eq, h_unord}), 32'(F_GT));
    chk("half.result", 32'(h_result), 32'h3C00);
    @(negedge clk);
    h_in_valid = 1'b1; h_a = 16'h3C00; h_b = 16'hBC00; h_op = MIN;
    @(negedge clk);
    h_in_valid = 1'b0;
    @(negedge clk);
    chk("half_min.result", 32'(h_result), 32'hBC00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_cmp_pipe.md
Name: fp_cmp_pipe

Overview:
- Parametrised, pipelined IEEE-754 comparator and min/max unit for the ALU.
- Successor to the single-cycle 32-bit compare block. Adds:
  - configurable exponent and mantissa widths
  - valid/ready handshake with backpressure
  - a fixed 2-cycle latency
  - correct signed-zero and NaN handling
  - MIN and MAX result modes
- Sits beside the add/mul units and feeds the ALU result mux and flag register.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, mantissa field width. Operand width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op present.
- in_ready  out  1  block can accept this cycle.
- op  in  2  00=CMP, 01=MIN, 10=MAX, 11=reserved (treated as CMP).
- A  in  W  operand A.
- B  in  W  operand B.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- gr  out  1  A > B.
- lr  out  1  A < B.
- eq  out  1  A == B.
- unord  out  1  at least one operand is NaN.
- result  out  W  MIN/MAX result; CMP mode returns A.
- snan  out  1  at least one operand is a signalling NaN (quiet bit, MSB of mantissa, = 0).

Behaviour:
- Reset, asynchronous on rst_n low: both stage valid bits clear, out_valid=0, gr=lr=eq=unord=snan=0, result=0. Takes effect mid-transfer; in-flight operations are discarded. in_ready=1 after reset.
- Pipeline:
  - S1 registers A, B and op. Classifies each operand: isNaN (exp all ones, man≠0), isZero (exp=0, man=0), sNaN. Registers the unsigned magnitude compare of bits [W-2:0] (mag_gt, mag_eq).
  - S2 resolves signs and produces all outputs registered.
- Latency: exactly 2 cycles from accepted input to out_valid with no stall. Throughput 1 per cycle.
- Handshake:
  - Input accepted when in_valid & in_ready.
  - Output consumed when out_valid & out_ready.
  - s2_adv = ~s2_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready and state).
  - Outputs hold stable while out_valid=1 and out_ready=0.
  - No bubble is inserted when the pipe is full and drains and fills in the same cycle.
- Compare rules, exactly one of {gr, lr, eq, unord} set per result:
  - Either operand NaN → unord=1, others 0.
  - Both zero, any signs → eq=1.
  - Signs differ → positive operand is greater.
  - Both positive → ordering follows magnitude.
  - Both negative → ordering inverted. eq when mag_eq.
  - Infinities and subnormals order by bit magnitude; no special casing.
- MIN/MAX:
  - Exactly one NaN → return the other operand.
  - Both NaN → canonical qNaN: sign 0, exp all ones, man MSB 1, rest 0.
  - MIN(+0,-0)=MIN(-0,+0)=-0. MAX of the same pair = +0.
  - Otherwise return the lesser/greater operand. When eq, return A.
- Flags gr/lr/eq/unord are valid in all modes.

Optional Feature:
- Macro FP_CMP_INVALID_STICKY_EN.
- When defined:
  - Extra output invalid_sticky (1 bit), reset 0.
  - Sets on any consumed result with snan=1, or with unord=1 in CMP mode.
  - Holds until extra input clr_sticky (1 bit) is pulsed high for one cycle.
  - Set and clear in the same cycle → set wins.
- When undefined: neither port exists; snan output is unaffected.

Test Plan:
- Default widths:
  - A=0x3F800000, B=0x40000000, op=CMP → after 2 cycles gr=0, lr=1, eq=0, unord=0.
  - A=0x80000000, B=0x00000000, op=CMP → eq=1.
  - op=MIN → result=0x80000000.
  - op=MAX → result=0x00000000.
- A=0xC0400000, B=0xBF800000 (-3 vs -1), op=MAX → lr=1, result=0xBF800000.
- A=0x7FC00000, B=0x3F800000, op=MIN → unord=1, result=0x3F800000, snan=0.
- A=0x7F800001 (sNaN), B=0x7F800001, op=MAX → result=0x7FC00000, snan=1. With FP_CMP_INVALID_STICKY_EN, invalid_sticky=1 until clr_sticky.
- Stream of 8 back-to-back operations with out_ready low for cycles 3-5:
  - in_ready falls once both stages are full.
  - Results are in order, none lost or duplicated, outputs stable while stalled.
  - Throughput returns to 1 per cycle after release.
- rst_n asserted low asynchronously with both stages full → out_valid=0 immediately, in_ready=1 after release, no stale result emitted.
- Override EXP_W=5, MAN_W=10 (half precision): A=0x3C00, B=0xBC00, op=CMP → gr=1.
